best_arr_sender: RTL and testbench
==================================

Name: best_arr_sender

Overview:
- Output-stage sequencer between the best-match index memory and the output FIFO write port.
- On `send_best_arr`, walks the best-index array in the blocked scan order the host expects: px, then x-block, then row y, then xi within block.
- Reads each entry from the 1-cycle-latency index SRAM and enqueues it to the output FIFO, honouring full backpressure.
- Sustains one word per clock when the FIFO is not full.

Parameters:
- DATA_WIDTH, 11, index word width.
- ROW_SIZE, 26, query patches per image row (must be even).
- COL_SIZE, 19, image rows.
- BLOCKING, 4, columns per x-block.
- NUM_QUERYS, ROW_SIZE*COL_SIZE, total entries.
- ADDR_WIDTH, $clog2(NUM_QUERYS), memory address width.
- NUM_BLK_X, ceil((ROW_SIZE/2)/BLOCKING), x-blocks per half-row (4 at defaults).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- send_best_arr  input  1  start pulse.
- busy  output  1  high from the accepted start until the last word is enqueued.
- done  output  1  one-cycle pulse after the last enqueue.
- mem_ren  output  1  index memory read enable.
- mem_raddr  output  ADDR_WIDTH  linear image index to read.
- mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_ren.
- fifo_wenq  output  1  enqueue strobe.
- fifo_wdata  output  DATA_WIDTH  enqueued index.
- fifo_wfull_n  input  1  FIFO not full; an enqueue occurs only when fifo_wenq && fifo_wfull_n.

Behaviour:
- Reset: all outputs 0; counters 0; skid buffer empty; state IDLE. Reset asserted mid-transfer aborts immediately with no further reads or enqueues. The next start begins from index 0.
- States:
  - IDLE: send_best_arr=1 → RUN at the next edge; busy=1 from that edge.
  - RUN: issues reads in scan order until the final address is issued → DRAIN.
  - DRAIN: waits until the in-flight read and the buffer are empty → DONE.
  - DONE: done=1, busy=0 for one cycle → IDLE.
- send_best_arr while busy is ignored. send_best_arr in the DONE cycle is also ignored.
- Scan order, nested loops from outermost to innermost:
  - px in 0..1
  - x in 0..NUM_BLK_X-1
  - y in 0..COL_SIZE-1
  - xi in 0..BLOCKING-1
- A tuple is valid iff x*BLOCKING+xi < ROW_SIZE/2. Invalid tuples are skipped in zero cycles, with no bubble.
- mem_raddr = px*(ROW_SIZE/2) + y*ROW_SIZE + x*BLOCKING + xi, computed incrementally (no multipliers). Width ADDR_WIDTH; no wrap is possible.
- Total enqueues: exactly NUM_QUERYS (494 at defaults). Each address is read exactly once.
- Buffering:
  - 2-entry skid FIFO holds returned data; its head drives fifo_wdata/fifo_wenq from registers.
  - A read is issued only if (buffer count + in-flight read) < 2. Words are therefore never lost under backpressure.
  - Buffer push (read return) and pop (accepted enqueue) may occur in the same cycle; count is unchanged.
- Latency: start sampled at edge N; mem_ren high in cycle N+1; first fifo_wenq in cycle N+3.
- Throughput with fifo_wfull_n held 1: one enqueue per cycle, no gaps. The last enqueue is in cycle N+2+NUM_QUERYS and done pulses in the following cycle.
- Backpressure:
  - With fifo_wfull_n=0, fifo_wenq may stay high and fifo_wdata stays stable until accepted.
  - At most 2 reads are outstanding or buffered; mem_ren drops within one cycle.
  - Resumption restores 1 word/cycle with no reordering.
- mem_ren is never asserted in IDLE, DRAIN or DONE.

Test Plan:
- Defaults, fifo_wfull_n=1, memory preloaded mem[i]=i, pulse start:
  - 494 enqueues, the first in cycle N+3, then continuous.
  - Write sequence begins 0,1,2,3,26,27,28,29,52…; after x=2 comes x=3 giving 12,38,64…; px=1 begins 13,14,15,16,39.
  - done pulses once, in the cycle after the last write.
- Same stimulus with fifo_wfull_n toggled pseudo-randomly at 50%:
  - Identical ordered 494-word sequence; no duplicates or drops.
  - fifo_wdata stable while fifo_wenq && !fifo_wfull_n.
  - mem_ren never asserted while buffer+in-flight = 2.
- fifo_wfull_n=0 for 20 cycles right after start:
  - Exactly 2 reads issued (addresses 0 and 1), then mem_ren stays 0.
  - On release, words 0,1,2… follow at 1/cycle.
- Second send_best_arr pulse mid-transfer, plus one in the DONE cycle:
  - Ignored; still exactly 494 words and one done pulse.
- rst_n asserted after 100 enqueues, then released and restarted:
  - Outputs drop to 0 asynchronously.
  - Restart produces the full sequence from address 0.
- ROW_SIZE=16, COL_SIZE=2, BLOCKING=4:
  - NUM_BLK_X=2; 32 enqueues with no skipped tuples.
  - Order 0,1,2,3,16,17,18,19,4,…,23; px=1 begins at 8.

Source files
------------

// File: rtl/best_arr_sender.sv
// best_arr_sender: streams the best-index array in blocked scan order from the index SRAM into the output FIFO.
// A 2-entry skid buffer plus credit-gated reads keeps one word per clock without losing data under backpressure.
module best_arr_sender #(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDR_WIDTH = $clog2(NUM_QUERYS),
    parameter int NUM_BLK_X  = (ROW_SIZE / 2 + BLOCKING - 1) / BLOCKING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  send_best_arr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_wenq,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_wfull_n
);
    localparam int HALF   = ROW_SIZE / 2;
    localparam int LAST_W = HALF - (NUM_BLK_X - 1) * BLOCKING;
    localparam int XW     = $clog2(NUM_BLK_X + 1);
    localparam int YW     = $clog2(COL_SIZE + 1);
    localparam int IW     = $clog2(BLOCKING + 1);
    localparam logic [XW-1:0] X_LAST = XW'(NUM_BLK_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(COL_SIZE - 1);
    localparam logic [IW-1:0] I_FULL = IW'(BLOCKING - 1);
    localparam logic [IW-1:0] I_PART = IW'(LAST_W - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ROW  = ADDR_WIDTH'(ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] A_BLK  = ADDR_WIDTH'(BLOCKING);
    localparam logic [ADDR_WIDTH-1:0] A_HALF = ADDR_WIDTH'(HALF);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic                  px;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [IW-1:0]         xi;
    logic [ADDR_WIDTH-1:0] addr, row_start, blk_base;
    logic                  rvalid;
    logic [1:0]            count, occ;
    logic [DATA_WIDTH-1:0] head, tail;
    logic                  pop, issue, blk_end, row_end, last;

    // occ is the buffer occupancy after this edge if no new read were issued
    assign pop     = (count != 2'd0) && fifo_wfull_n;
    assign occ     = count + {1'b0, rvalid} - {1'b0, pop};
    assign issue   = (state == RUN) && (occ < 2'd2);
    assign blk_end = xi == ((x == X_LAST) ? I_PART : I_FULL);
    assign row_end = blk_end && (y == Y_LAST);
    assign last    = row_end && px && (x == X_LAST);

    assign mem_ren    = issue;
    assign mem_raddr  = addr;
    assign fifo_wenq  = count != 2'd0;
    assign fifo_wdata = head;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (send_best_arr) state_nx = RUN;
            RUN:     if (issue && last) state_nx = DRAIN;
            DRAIN:   if (!rvalid && occ == 2'd0) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // partial last block is skipped past directly, so invalid tuples cost no cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || (state == IDLE && send_best_arr)) begin
            px        <= 1'b0;
            x         <= '0;
            y         <= '0;
            xi        <= '0;
            addr      <= '0;
            row_start <= '0;
            blk_base  <= '0;
        end else if (issue && !last) begin
            if (!blk_end) begin
                xi   <= xi + 1'b1;
                addr <= addr + 1'b1;
            end else if (!row_end) begin
                xi        <= '0;
                y         <= y + 1'b1;
                row_start <= row_start + A_ROW;
                addr      <= row_start + A_ROW;
            end else begin
                xi <= '0;
                y  <= '0;
                if (x != X_LAST) begin
                    x         <= x + 1'b1;
                    blk_base  <= blk_base + A_BLK;
                    row_start <= blk_base + A_BLK;
                    addr      <= blk_base + A_BLK;
                end else begin
                    x         <= '0;
                    px        <= 1'b1;
                    blk_base  <= A_HALF;
                    row_start <= A_HALF;
                    addr      <= A_HALF;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else begin
            rvalid <= issue;
            case ({rvalid, pop})
                2'b10: begin
                    if (count == 2'd0) head <= mem_rdata;
                    else               tail <= mem_rdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) head <= mem_rdata;
                    else begin
                        head <= tail;
                        tail <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_best_arr_sender.sv
// tb_best_arr_sender: scoreboard bench for best_arr_sender at default size and at a 16x2 image.
// A behavioural model of the scan order fills the expected queue; each accepted FIFO write pops it.
module tb_best_arr_sender;
    logic        clk = 1'b0;
    logic        rst_n, send_best_arr, fifo_wfull_n;
    logic        busy, done, mem_ren, fifo_wenq;
    logic [8:0]  mem_raddr;
    logic [10:0] mem_rdata = '0, fifo_wdata;
    logic        s_send, s_full_n, s_busy, s_done, s_ren, s_wenq;
    logic [4:0]  s_raddr;
    logic [10:0] s_rdata = '0, s_wdata;
    int          checks = 0, errors = 0;
    logic [10:0] exp_q[$];

    best_arr_sender dut (
        .clk(clk), .rst_n(rst_n), .send_best_arr(send_best_arr), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .fifo_wenq(fifo_wenq), .fifo_wdata(fifo_wdata), .fifo_wfull_n(fifo_wfull_n)
    );

    best_arr_sender #(.ROW_SIZE(16), .COL_SIZE(2), .BLOCKING(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .send_best_arr(s_send), .busy(s_busy), .done(s_done),
        .mem_ren(s_ren), .mem_raddr(s_raddr), .mem_rdata(s_rdata),
        .fifo_wenq(s_wenq), .fifo_wdata(s_wdata), .fifo_wfull_n(s_full_n)
    );

    always #5 clk = ~clk;

    // index memories preloaded with mem[i] = i, one cycle read latency
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= 11'(mem_raddr);
        if (s_ren)   s_rdata   <= 11'(s_raddr);
    end

    function automatic void fill_exp(input int rs, input int cs, input int bl);
        int half = rs / 2;
        int nbx  = (half + bl - 1) / bl;
        exp_q.delete();
        for (int p = 0; p < 2; p++)
            for (int bx = 0; bx < nbx; bx++)
                for (int r = 0; r < cs; r++)
                    for (int i = 0; i < bl; i++)
                        if (bx * bl + i < half) exp_q.push_back(11'(p * half + r * rs + bx * bl + i));
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b ren=%b wenq=%b raddr=%0d wdata=%0d, need all 0",
                     busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata);
        end
        checks++;
        if ({s_busy, s_done, s_ren, s_wenq, s_raddr, s_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_small: got busy=%b done=%b ren=%b wenq=%b, need all 0", s_busy, s_done, s_ren, s_wenq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, mem_ren, fifo_wenq} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b ren=%b wenq=%b, need 0000", busy, done, mem_ren, fifo_wenq);
        end
    endtask

    // mode 0: free flow, 1: random backpressure, 2: stalled for 20 cycles, 3: extra ignored starts
    task automatic test_stream(input int mode);
        int got = 0, dones = 0, first_c = 0, last_c = 0, done_c = 0, reads = 0;
        int stall_reads = 0, bad_addr = 0, ovf = 0, unstable = 0, bad_busy = 0;
        logic        held = 1'b0;
        logic [10:0] held_data = '0, e;
        fill_exp(26, 19, 4);
        @(negedge clk);
        send_best_arr = 1'b1;
        fifo_wfull_n  = mode != 2;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            send_best_arr = (mode == 3) && (c == 50 || c == 497);
            fifo_wfull_n  = mode == 1 ? 1'($urandom_range(0, 1)) : !(mode == 2 && c <= 20);
            #1;
            if (mem_ren) reads++;
            if (mode == 2 && c <= 20 && mem_ren) begin
                if (mem_raddr !== 9'(stall_reads)) bad_addr++;
                stall_reads++;
            end
            if (held && (!fifo_wenq || fifo_wdata !== held_data)) unstable++;
            if (fifo_wenq && fifo_wfull_n) begin
                got++;
                last_c = c;
                if (first_c == 0) first_c = c;
                e = exp_q.size() > 0 ? exp_q.pop_front() : 11'h7ff;
                checks++;
                if (fifo_wdata !== e) begin
                    errors++;
                    $display("FAIL word[%0d] mode %0d: got %0d expected %0d", got - 1, mode, fifo_wdata, e);
                end
            end
            if (reads - got > 2) ovf++;
            if (c == 1 && !busy) bad_busy++;
            if (done) begin
                dones++;
                done_c = c;
                if (busy) bad_busy++;
            end
            held      = fifo_wenq && !fifo_wfull_n;
            held_data = fifo_wdata;
            if (dones > 0 && c >= done_c + 8) break;
        end
        send_best_arr = 1'b0;
        fifo_wfull_n  = 1'b1;
        checks++;
        if (got != 494 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL word_count mode %0d: got %0d words (%0d unmatched), need 494", mode, got, exp_q.size());
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL done_pulses mode %0d: got %0d need 1", mode, dones); end
        checks++;
        if (reads != 494) begin errors++; $display("FAIL read_count mode %0d: got %0d need 494", mode, reads); end
        checks++;
        if (ovf != 0) begin errors++; $display("FAIL outstanding mode %0d: %0d cycles above 2", mode, ovf); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL held_data mode %0d: %0d unstable cycles, need 0", mode, unstable); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL busy mode %0d: %0d bad samples, need 0", mode, bad_busy); end
        if (mode == 0 || mode == 3) begin
            checks++;
            if (first_c != 3 || last_c != 496 || done_c != 497) begin
                errors++;
                $display("FAIL timing mode %0d: first=%0d last=%0d done=%0d, need 3 496 497", mode, first_c, last_c, done_c);
            end
        end
        if (mode == 2) begin
            checks++;
            if (stall_reads != 2 || bad_addr != 0) begin
                errors++;
                $display("FAIL stall_reads: got %0d reads (%0d wrong addr), need 2 at 0,1", stall_reads, bad_addr);
            end
            checks++;
            if (first_c != 21 || last_c != 514 || done_c != 515) begin
                errors++;
                $display("FAIL stall_timing: first=%0d last=%0d done=%0d, need 21 514 515", first_c, last_c, done_c);
            end
        end
    endtask

    task automatic test_reset_mid;
        int got = 0;
        @(negedge clk);
        send_best_arr = 1'b1;
        for (int c = 1; c <= 1000 && got < 100; c++) begin
            @(negedge clk);
            send_best_arr = 1'b0;
            #1;
            if (fifo_wenq && fifo_wfull_n) got++;
        end
        checks++;
        if (got != 100) begin errors++; $display("FAIL reset_mid_progress: got %0d words need 100", got); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b ren=%b wenq=%b raddr=%0d wdata=%0d, need all 0",
                     busy, mem_ren, fifo_wenq, mem_raddr, fifo_wdata);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_ren || fifo_wenq) begin errors++; $display("FAIL reset_hold: ren=%b wenq=%b need 0 0", mem_ren, fifo_wenq); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_stream(0);
    endtask

    task automatic test_small;
        int got = 0, dones = 0, last_c = 0, done_c = 0;
        logic [10:0] e;
        fill_exp(16, 2, 4);
        @(negedge clk);
        s_send = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            s_send = 1'b0;
            #1;
            if (s_wenq && s_full_n) begin
                got++;
                last_c = c;
                e = exp_q.size() > 0 ? exp_q.pop_front() : 11'h7ff;
                checks++;
                if (s_wdata !== e) begin
                    errors++;
                    $display("FAIL small_word[%0d]: got %0d expected %0d", got - 1, s_wdata, e);
                end
            end
            if (s_done) begin dones++; done_c = c; end
            if (dones > 0 && c >= done_c + 5) break;
        end
        checks++;
        if (got != 32 || dones != 1 || last_c != 34 || done_c != 35) begin
            errors++;
            $display("FAIL small_run: words=%0d dones=%0d last=%0d done=%0d, need 32 1 34 35", got, dones, last_c, done_c);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        send_best_arr = 1'b0;
        fifo_wfull_n = 1'b1;
        s_send = 1'b0;
        s_full_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        test_stream(0);
        test_stream(1);
        test_stream(2);
        test_stream(3);
        test_reset_mid;
        test_small;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
